// File: rtl/mem_resp_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, RW polarity,
// and the wait-state counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous data RAM, DATA_W x 2**DEPTH_LOG2, with registered read data.
module data_ram_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: captures a request, waits WAIT_STATES cycles, then acks with read data.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              RW,
  input  logic [31:0]       address_in,
  input  logic [DATA_W-1:0] RAM_in,
  output logic [DATA_W-1:0] RAM_out,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    rw_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [DATA_W-1:0]       data_q;
  logic                    oob_q;
  logic [DATA_W-1:0]       held_q;

  logic                    live_oob;
  logic                    capture;
  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;
  logic [DATA_W-1:0]       rd_data;
  logic                    resp_read;
  logic                    addr_unused;

`ifdef MEM_BOUNDS_CHECK_EN
  assign live_oob = |(address_in >> (DEPTH_LOG2 + 2));
`else
  assign live_oob = 1'b0;
`endif
  assign addr_unused = &{1'b0, address_in[1:0], address_in[31:DEPTH_LOG2+2]};

  assign capture = (state_q == IDLE) && req;

  // With zero wait states the RAM is accessed on the capture edge itself,
  // so in IDLE the array sees the live request rather than the capture registers.
  assign ram_addr = (state_q == IDLE) ? address_in[DEPTH_LOG2+1:2] : addr_q;
  assign ram_din  = (state_q == IDLE) ? RAM_in : data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            ram_we  = (RW == RW_WRITE) && !live_oob;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ram_we  = (rw_q == RW_WRITE) && !oob_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_WRITE;
      addr_q  <= '0;
      data_q  <= '0;
      oob_q   <= 1'b0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        rw_q   <= RW;
        addr_q <= address_in[DEPTH_LOG2+1:2];
        data_q <= RAM_in;
        oob_q  <= live_oob;
      end
      if (resp_read) begin
        held_q <= rd_data;
      end
    end
  end

  data_ram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // The array output is shown directly in the ack cycle and latched for the hold period after.
  assign resp_read = (state_q == RESP) && (rw_q == RW_READ);
  assign rd_data   = oob_q ? '0 : ram_dout;
  assign RAM_out   = resp_read ? rd_data : held_q;
  assign ack       = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign err       = (state_q == RESP) && oob_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with 2 wait states, one with none,
// checked against an array model of the word memory.
module tb_data_mem_responder;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, rw_a = 1'b1, req_b = 1'b0, rw_b = 1'b1;
  logic [31:0] addr_a = '0, din_a = '0, addr_b = '0, din_b = '0;
  logic [31:0] out_a, out_b;
  logic        ack_a, busy_a, err_a, ack_b, busy_b, err_b;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] model_mem [2][256];
  bit          written   [2][256];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .RW(rw_a), .address_in(addr_a),
    .RAM_in(din_a), .RAM_out(out_a), .ack(ack_a), .busy(busy_a), .err(err_a)
  );

  data_mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .RW(rw_b), .address_in(addr_b),
    .RAM_in(din_b), .RAM_out(out_b), .ack(ack_b), .busy(busy_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic g_ack(input int sel);
    return sel == 0 ? ack_a : ack_b;
  endfunction
  function automatic logic g_busy(input int sel);
    return sel == 0 ? busy_a : busy_b;
  endfunction
  function automatic logic g_err(input int sel);
    return sel == 0 ? err_a : err_b;
  endfunction
  function automatic logic [31:0] g_out(input int sel);
    return sel == 0 ? out_a : out_b;
  endfunction

  task automatic drive(input int sel, input logic r, input logic rw, input logic [31:0] a,
                       input logic [31:0] d);
    if (sel == 0) begin
      req_a = r; rw_a = rw; addr_a = a; din_a = d;
    end else begin
      req_b = r; rw_b = rw; addr_b = a; din_b = d;
    end
  endtask

  // One complete request: capture, wait for ack within a bounded window, check, then idle cycle.
  task automatic txn(input int sel, input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    int          ws, k, idx;
    bit          seen, oob, known;
    logic [31:0] exp;
    ws  = (sel == 0) ? 2 : 0;
    idx = int'((addr >> 2) % 256);
    oob = BOUNDS && (addr >= 32'd1024);
    @(negedge clk);
    drive(sel, 1'b1, rw, addr, wdata);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
    if (rw == 1'b0 && !oob) begin
      model_mem[sel][idx] = wdata;
      written[sel][idx]   = 1'b1;
    end
    known = oob || written[sel][idx];
    exp   = oob ? 32'h0 : model_mem[sel][idx];
    seen = 1'b0;
    k    = 0;
    while (!seen && k <= 20) begin
      if (g_ack(sel)) seen = 1'b1;
      else begin
        chk("busy_wait", 32'(g_busy(sel)), 32'd1);
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk("ack_latency", k, ws);
    chk("busy_ack", 32'(g_busy(sel)), 32'd1);
    chk("err", 32'(g_err(sel)), 32'(oob));
    if (rw == 1'b1 && known) chk("rdata", g_out(sel), exp);
    @(posedge clk);
    #1;
    chk("ack_pulse", 32'(g_ack(sel)), 32'd0);
    chk("busy_end", 32'(g_busy(sel)), 32'd0);
    if (rw == 1'b1 && known) chk("rdata_hold", g_out(sel), exp);
  endtask

  initial begin
    int acks;
    logic [31:0] a, d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ack", {30'd0, ack_a, ack_b}, 32'd0);
      chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
      chk("rst_err", {30'd0, err_a, err_b}, 32'd0);
      chk("rst_out_a", out_a, 32'd0);
      chk("rst_out_b", out_b, 32'd0);
    end

    txn(0, 1'b0, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 32'h0);

    // Second request while busy must be dropped.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h14, 32'hAAAA0000);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 32'h0, 32'h0);
    model_mem[0][5] = 32'hAAAA0000;
    written[0][5]   = 1'b1;
    acks = 0;
    if (ack_a) acks++;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 32'h0, 32'h0);
    if (ack_a) acks++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ack_a) acks++;
    end
    chk("one_ack", acks, 1);
    txn(0, 1'b1, 32'h10, 32'h0);
    txn(0, 1'b1, 32'h14, 32'h0);

    // Zero wait states, back-to-back reads.
    txn(1, 1'b0, 32'h40, 32'h11112222);
    txn(1, 1'b0, 32'h44, 32'h33334444);
    for (int i = 0; i < 4; i++) txn(1, 1'b1, (i % 2 == 0) ? 32'h40 : 32'h44, 32'h0);

    // Reset on the edge that would have committed a write.
    txn(0, 1'b0, 32'h20, 32'h0000CAFE);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h20, 32'h00001234);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wait_busy", 32'(busy_a), 32'd0);
    chk("rst_wait_ack", 32'(ack_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack_a) acks++;
    end
    chk("rst_no_ack", acks, 0);
    txn(0, 1'b1, 32'h20, 32'h0);

    // Aliasing / bounds check on an address beyond the array.
    txn(0, 1'b0, 32'h0, 32'h00000077);
    txn(0, 1'b0, 32'h400, 32'h00000055);
    txn(0, 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a = {($urandom_range(0, 4) == 0) ? 22'($urandom) : 22'd0,
           8'($urandom_range(0, 15)), 2'($urandom)};
      d = $urandom;
      txn(i % 2, 1'($urandom), a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
